dsp_mac_lanes: RTL and testbench
================================

# dsp_mac_lanes

Five-lane pipelined unsigned multiply/multiply-accumulate array that sits on the DSP side of the matrix multiplier's slice interface. It consumes the `dsp_a0`/`dsp_b0` operand buses and `dsp_ce`, and returns `dsp_out` per lane. It is a behavioural stand-in for the hard DSP slices, used in simulation and on targets without DSP48 primitives. It mirrors their A/B → M → P register structure and clock-enable semantics.

## Interface

Parameters:
- `LANES`, 5: number of independent multiplier lanes.
- `AW`, 18: operand A width.
- `BW`, 18: operand B width.
- `OW`, 37: result width; must satisfy OW ≥ AW+BW+1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `dsp_ce`  in  1: pipeline clock enable. Low: every pipeline register holds.
- `dsp_a0[0:LANES-1]`  in  AW each: unsigned operand A per lane.
- `dsp_b0[0:LANES-1]`  in  BW each: unsigned operand B per lane.
- `acc_en`  in  1: per-issue mode tag. 0 = multiply, 1 = multiply-accumulate. Sampled with the operands.
- `acc_clr`  in  1: synchronous clear of all P registers and overflow flags.
- `dsp_out[0:LANES-1]`  out  OW each: P register per lane.
- `out_valid`  out  1: high once P holds a result from a ce-qualified issue.
- `overflow[LANES-1:0]`  out  LANES: sticky per-lane accumulate saturation flag.

## Operation

Per lane, three register stages:
- A0/B0: capture `dsp_a0`/`dsp_b0`.
- M: `A0*B0`, zero-extended to OW.
- P: accumulator/output.

The `acc_en` tag and a valid bit travel alongside the data in shift registers `t0/t1` and `v0/v1/v2`. `v0` loads 1.

All stages advance only on edges where `dsp_ce`=1. On an advancing edge, P loads:
- M, if the M-stage tag = 0;
- sat(P + M), if the M-stage tag = 1. The sum is computed at OW+1 bits. If bit OW is set, P <= all ones and `overflow[lane]` <= 1.

Priority per edge:
1. `rst`: all registers, `dsp_out`, `out_valid`, and `overflow` go to 0.
2. `acc_clr`: P and `overflow` go to 0 for all lanes. A0/B0, M, tags, and valid bits still advance if `dsp_ce`=1. The M-stage product is discarded on that edge.
3. Normal advance or hold, per `dsp_ce`.

Other rules:
- `out_valid` = `v2`. Once the pipeline is primed it stays high until `rst`. `dsp_ce`=0 holds it.
- Arithmetic is unsigned only. The maximum product (2^18-1)^2 fits in 36 bits, so multiply mode never sets `overflow`.
- All lanes share `dsp_ce`, `acc_en`, and `acc_clr`. Operands are independent per lane.

## Timing

- Reset values: `dsp_out`=0 on every lane, `out_valid`=0, `overflow`=0.
- Latency is 3 ce-qualified edges. Operands presented with `dsp_ce`=1 at edge N appear on `dsp_out` after edge N+2, if ce is high on all three edges. Each ce-low edge in between adds one cycle.
- Throughput: one issue per cycle per lane.
- `out_valid` rises after the third ce-qualified edge following reset.
- `acc_clr` takes effect after the edge that samples it, independent of `dsp_ce`.
- `rst` mid-stream discards all in-flight data. Outputs read 0 starting the cycle after the reset edge.
- `overflow` changes only on a saturating accumulate, `acc_clr`, or `rst`.

## Test plan

- Multiply latency: lane0 a=3,b=5, `dsp_ce`=1 continuous, `acc_en`=0 → `dsp_out[0]`=15 after exactly 3 edges; `out_valid` rises the same cycle.
- Accumulate: lane2 issues (2,7),(4,4),(1,1) with `acc_en`=1 after an `acc_clr` → `dsp_out[2]` steps 14, 30, 31 on consecutive cycles.
- CE stall: issue a=10,b=10, drop `dsp_ce` for 4 cycles after edge 1 → `dsp_out` stays at its previous value during the stall and reads 100 only after the third ce-qualified edge.
- Saturation: preload P near max via `acc_en`=1 with repeated (2^18-1, 2^18-1) for 3 issues → P = 2^37-1 and `overflow[lane]`=1, and both stay so on further issues. `acc_clr` → P=0, flag=0.
- Clear/advance collision: `acc_clr`=1 and `dsp_ce`=1 on the same edge with data in flight → P=0 after that edge, and the following in-flight result lands normally.
- Reset mid-stream: assert `rst` with all 5 lanes busy → `dsp_out`=0, `out_valid`=0, `overflow`=0 next cycle. First output arrives 3 ce-edges after `rst` deasserts.

Source files
------------

// File: rtl/dsp_mac_lanes.sv
// Behavioural DSP-slice array: per-lane A0/B0 -> M -> P pipeline (3 ce-qualified edges),
// unsigned multiply or saturating multiply-accumulate, shared clock enable / mode / clear.
module dsp_mac_lanes #(
  parameter int LANES = 5,
  parameter int AW    = 18,
  parameter int BW    = 18,
  parameter int OW    = 37
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dsp_ce,
  input  logic [AW-1:0]        dsp_a0 [0:LANES-1],
  input  logic [BW-1:0]        dsp_b0 [0:LANES-1],
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic [OW-1:0]        dsp_out [0:LANES-1],
  output logic                 out_valid,
  output logic [LANES-1:0]     overflow
);

  logic [AW-1:0]    a0_q [0:LANES-1];
  logic [BW-1:0]    b0_q [0:LANES-1];
  logic [OW-1:0]    m_q  [0:LANES-1];
  logic [AW+BW-1:0] prod [0:LANES-1];
  logic [OW:0]      sum  [0:LANES-1];
  logic             t0, t1;
  logic             v0, v1, v2;

  // Sum carries one extra bit so a carry out of OW bits signals saturation.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = {{BW{1'b0}}, a0_q[l]} * {{AW{1'b0}}, b0_q[l]};
      sum[l]  = {1'b0, dsp_out[l]} + {1'b0, m_q[l]};
    end
  end

  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        a0_q[l]    <= '0;
        b0_q[l]    <= '0;
        m_q[l]     <= '0;
        dsp_out[l] <= '0;
      end
      overflow <= '0;
      t0 <= 1'b0;
      t1 <= 1'b0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (dsp_ce) begin
        for (int l = 0; l < LANES; l++) begin
          a0_q[l] <= dsp_a0[l];
          b0_q[l] <= dsp_b0[l];
          m_q[l]  <= {{(OW-AW-BW){1'b0}}, prod[l]};
        end
        t0 <= acc_en;
        t1 <= t0;
        v0 <= 1'b1;
        v1 <= v0;
        v2 <= v1;
      end
      // Clear wins over the P update regardless of ce; the M-stage product is dropped.
      for (int l = 0; l < LANES; l++) begin
        if (acc_clr) begin
          dsp_out[l]  <= '0;
          overflow[l] <= 1'b0;
        end else if (dsp_ce) begin
          if (!t1) begin
            dsp_out[l] <= m_q[l];
          end else if (sum[l][OW]) begin
            dsp_out[l]  <= {OW{1'b1}};
            overflow[l] <= 1'b1;
          end else begin
            dsp_out[l] <= sum[l][OW-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_lanes.sv
// Directed bench for dsp_mac_lanes: vector table for pipelined mul/mac plus corner sequences.
module tb_dsp_mac_lanes;

  localparam int L = 5;
  localparam logic [17:0] MX   = 18'h3FFFF;
  localparam logic [36:0] ONES = 37'h1F_FFFF_FFFF;
  localparam logic [36:0] MSQ  = 37'd68718952449;

  logic        clk = 1'b0;
  logic        rst, dsp_ce, acc_en, acc_clr;
  logic [17:0] a [0:L-1];
  logic [17:0] b [0:L-1];
  logic [36:0] dout [0:L-1];
  logic        out_valid;
  logic [L-1:0] overflow;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [0:4][17:0] a;
    logic [0:4][17:0] b;
    logic             acc;
    logic [0:4][36:0] exp;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  dsp_mac_lanes dut (
    .clk(clk), .rst(rst), .dsp_ce(dsp_ce), .dsp_a0(a), .dsp_b0(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(dout),
    .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all(input logic [17:0] av, input logic [17:0] bv);
    for (int l = 0; l < L; l++) begin
      a[l] = av;
      b[l] = bv;
    end
  endtask

  initial begin
    vecs[0] = '{a: {18'd1, 18'd2, 18'd3, 18'd4, 18'd5},
                b: {18'd6, 18'd7, 18'd8, 18'd9, 18'd10}, acc: 1'b0,
                exp: {37'd6, 37'd14, 37'd24, 37'd36, 37'd50}};
    vecs[1] = '{a: {18'd0, 18'd100, MX, 18'd65536, 18'd7},
                b: {18'd12345, 18'd100, MX, 18'd4, 18'd0}, acc: 1'b0,
                exp: {37'd0, 37'd10000, MSQ, 37'd262144, 37'd0}};
    vecs[2] = '{a: {18'd1, 18'd1, 18'd1, 18'd1, 18'd1},
                b: {18'd1, 18'd2, 18'd3, 18'd4, 18'd5}, acc: 1'b1,
                exp: {37'd1, 37'd10002, 37'd68718952452, 37'd262148, 37'd5}};
    vecs[3] = '{a: {18'd10, 18'd0, MX, 18'd1, 18'd3},
                b: {18'd10, 18'd5, MX, 18'd1, 18'd3}, acc: 1'b1,
                exp: {37'd101, 37'd10002, 37'd137437904901, 37'd262149, 37'd14}};
    vecs[4] = '{a: {18'd9, 18'd9, 18'd9, 18'd9, 18'd9},
                b: {18'd9, 18'd9, 18'd9, 18'd9, 18'd9}, acc: 1'b0,
                exp: {37'd81, 37'd81, 37'd81, 37'd81, 37'd81}};
    vecs[5] = '{a: {MX, 18'd0, 18'd0, 18'd0, 18'd0},
                b: {MX, 18'd0, 18'd0, 18'd0, 18'd0}, acc: 1'b1,
                exp: {37'd68718952530, 37'd81, 37'd81, 37'd81, 37'd81}};

    rst = 1'b1; dsp_ce = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    set_all(18'd0, 18'd0);
    tick(); tick();
    for (int l = 0; l < L; l++) chk($sformatf("reset_out%0d", l), dout[l], 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1'b0;

    // Multiply latency on lane 0
    dsp_ce = 1'b1;
    a[0] = 18'd3; b[0] = 18'd5;
    tick();
    set_all(18'd0, 18'd0);
    chk("lat_e1_out", dout[0], 0);
    chk("lat_e1_valid", out_valid, 0);
    tick();
    chk("lat_e2_out", dout[0], 0);
    chk("lat_e2_valid", out_valid, 0);
    tick();
    chk("lat_e3_out", dout[0], 15);
    chk("lat_e3_valid", out_valid, 1);

    // Pipelined vector table: the result of vector k is on dsp_out after edge k+2
    for (int k = 0; k < NV + 2; k++) begin
      if (k < NV) begin
        for (int l = 0; l < L; l++) begin
          a[l] = vecs[k].a[l];
          b[l] = vecs[k].b[l];
        end
        acc_en = vecs[k].acc;
      end else begin
        set_all(18'd0, 18'd0);
        acc_en = 1'b0;
      end
      tick();
      if (k >= 2) begin
        for (int l = 0; l < L; l++)
          chk($sformatf("vec%0d_lane%0d", k - 2, l), dout[l], vecs[k-2].exp[l]);
        chk($sformatf("vec%0d_valid", k - 2), out_valid, 1);
        chk($sformatf("vec%0d_ovf", k - 2), overflow, 0);
      end
    end

    // Accumulate on lane 2 after a clear
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("acc_clr_out", dout[2], 0);
    acc_en = 1'b1;
    a[2] = 18'd2; b[2] = 18'd7; tick();
    a[2] = 18'd4; b[2] = 18'd4; tick();
    a[2] = 18'd1; b[2] = 18'd1; tick();
    chk("acc_step1", dout[2], 14);
    set_all(18'd0, 18'd0);
    tick();
    chk("acc_step2", dout[2], 30);
    tick();
    chk("acc_step3", dout[2], 31);

    // CE stall: 10*10 issued, then ce low for 4 cycles with junk inputs
    acc_en = 1'b0;
    a[2] = 18'd10; b[2] = 18'd10;
    tick();
    chk("stall_e1", dout[2], 31);
    dsp_ce = 1'b0; acc_en = 1'b1;
    a[2] = 18'd7; b[2] = 18'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall_hold%0d", i), dout[2], 31);
      chk($sformatf("stall_valid%0d", i), out_valid, 1);
    end
    dsp_ce = 1'b1; acc_en = 1'b0;
    set_all(18'd0, 18'd0);
    tick();
    chk("stall_e2", dout[2], 31);
    tick();
    chk("stall_e3", dout[2], 100);

    // Saturation on lane 4
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc_en = 1'b1;
    a[4] = MX; b[4] = MX;
    tick(); tick(); tick();
    chk("sat_p1", dout[4], MSQ);
    chk("sat_ovf1", overflow, 0);
    tick();
    chk("sat_p2", dout[4], 37'd137437904898);
    chk("sat_ovf2", overflow, 0);
    tick();
    chk("sat_p3", dout[4], ONES);
    chk("sat_ovf3", overflow, 5'b10000);
    set_all(18'd0, 18'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("sat_stay%0d", i), dout[4], ONES);
      chk($sformatf("sat_ovf_stay%0d", i), overflow, 5'b10000);
    end
    // Clear works with ce low
    dsp_ce = 1'b0; acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("sat_clr_out", dout[4], 0);
    chk("sat_clr_ovf", overflow, 0);

    // Clear colliding with an advancing edge on lane 3
    dsp_ce = 1'b1; acc_en = 1'b0;
    a[3] = 18'd6; b[3] = 18'd7; tick();
    a[3] = 18'd5; b[3] = 18'd5; tick();
    set_all(18'd0, 18'd0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("coll_clr", dout[3], 0);
    tick();
    chk("coll_next", dout[3], 25);

    // Reset mid-stream with every lane busy and saturated
    set_all(MX, MX); acc_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("busy_ovf", overflow, 5'b11111);
    chk("busy_out0", dout[0], ONES);
    rst = 1'b1;
    tick();
    for (int l = 0; l < L; l++) chk($sformatf("rst_out%0d", l), dout[l], 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0; acc_en = 1'b0;
    for (int l = 0; l < L; l++) begin
      a[l] = 18'(l + 1);
      b[l] = 18'd2;
    end
    tick();
    set_all(18'd0, 18'd0);
    chk("post_rst_valid1", out_valid, 0);
    tick();
    chk("post_rst_valid2", out_valid, 0);
    chk("post_rst_out2", dout[0], 0);
    tick();
    chk("post_rst_valid3", out_valid, 1);
    for (int l = 0; l < L; l++) chk($sformatf("post_rst_out%0d", l), dout[l], 2 * (l + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
